// File: rtl/sap1_control_sequencer_if.sv
// Sequencer handshake bundle: IR opcode and run/step controls in,
// ring state, control word and halt flag out.
interface sap1_control_sequencer_if;
    logic [3:0]  opcode;
    logic        run;
    logic        step;
    logic [5:0]  t_state;
    logic [11:0] con;
    logic        halted;

    modport master (
        output opcode, run, step,
        input  t_state, con, halted
    );

    modport slave (
        input  opcode, run, step,
        output t_state, con, halted
    );
endinterface

// File: rtl/sap1_control_sequencer.sv
// SAP-1 ring-counter controller-sequencer: T1..T6 timing states, opcode
// decode into the 12-bit datapath control word, free-run/single-step/HLT.
//
// state | meaning
// T1    | address state: PC onto bus, load MAR
// T2    | increment state: PC count
// T3    | memory state: RAM onto bus, load IR
// T4    | execute 1: opcode-dependent; HLT parks here
// T5    | execute 2: opcode-dependent
// T6    | execute 3: opcode-dependent, wraps to T1
module sap1_control_sequencer #(
    parameter logic [3:0] OP_LDA    = 4'h0,
    parameter logic [3:0] OP_ADD    = 4'h1,
    parameter logic [3:0] OP_SUB    = 4'h2,
    parameter logic [3:0] OP_OUT    = 4'hE,
    parameter logic [3:0] OP_HLT    = 4'hF,
    parameter int         SKIP_IDLE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    sap1_control_sequencer_if.slave         bus
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    localparam logic [11:0] CON_IDLE   = 12'h3E3;
    localparam logic [11:0] CON_FETCH1 = 12'h5E3;
    localparam logic [11:0] CON_FETCH2 = 12'hBE3;
    localparam logic [11:0] CON_FETCH3 = 12'h263;
    localparam logic [11:0] CON_MAR_IR = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

    ring_e       state_q, state_d;
    logic        halted_q, halted_d;
    logic        step_q;
    logic        adv;
    logic        is_undef;
    logic        skip_now;
    logic [11:0] con_w;

    always_comb begin
        adv      = ~halted_q & (bus.run | (bus.step & ~step_q));
        is_undef = (bus.opcode != OP_LDA) && (bus.opcode != OP_ADD) &&
                   (bus.opcode != OP_SUB) && (bus.opcode != OP_OUT) &&
                   (bus.opcode != OP_HLT);
        skip_now = (SKIP_IDLE != 0) &&
                   (((bus.opcode == OP_LDA) && (state_q == T5)) ||
                    ((bus.opcode == OP_OUT) && (state_q == T4)) ||
                    (is_undef && (state_q == T3)));
        state_d  = state_q;
        halted_d = halted_q;
        if (!halted_q) begin
            // HLT latches at T4 without needing a step, and parks the ring there.
            if ((state_q == T4) && (bus.opcode == OP_HLT)) begin
                halted_d = 1'b1;
            end else if (adv) begin
                if (skip_now) begin
                    state_d = T1;
                end else begin
                    state_d = ring_e'({state_q[4:0], state_q[5]});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            step_q   <= bus.step;
        end
    end

    always_comb begin
        con_w = CON_IDLE;
        unique case (state_q)
            T1: con_w = CON_FETCH1;
            T2: con_w = CON_FETCH2;
            T3: con_w = CON_FETCH3;
            T4: begin
                if ((bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB))
                    con_w = CON_MAR_IR;
                else if (bus.opcode == OP_OUT)
                    con_w = CON_OUT_T4;
            end
            T5: begin
                if (bus.opcode == OP_LDA)
                    con_w = CON_LDA_T5;
                else if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB))
                    con_w = CON_ALU_T5;
            end
            T6: begin
                if (bus.opcode == OP_ADD)
                    con_w = CON_ADD_T6;
                else if (bus.opcode == OP_SUB)
                    con_w = CON_SUB_T6;
            end
            default: con_w = CON_IDLE;
        endcase
        // Reset and halt both force every enable inactive, independent of state.
        if (rst || halted_q)
            con_w = CON_IDLE;
    end

    assign bus.t_state = state_q;
    assign bus.con     = con_w;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Scoreboard bench for sap1_control_sequencer: full-ring and skip-idle instances.
module tb_sap1_control_sequencer;
    logic clk;
    logic rst_a, rst_b;
    int   checks;
    int   failures;

    typedef struct {
        int          d;
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
        string       n;
    } exp_t;

    exp_t sb[$];

    sap1_control_sequencer_if ifa ();
    sap1_control_sequencer_if ifb ();

    sap1_control_sequencer #(.SKIP_IDLE(0)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    sap1_control_sequencer #(.SKIP_IDLE(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t        e;
        logic [5:0]  at;
        logic [11:0] ac;
        logic        ah;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            at = (e.d == 0) ? ifa.t_state : ifb.t_state;
            ac = (e.d == 0) ? ifa.con     : ifb.con;
            ah = (e.d == 0) ? ifa.halted  : ifb.halted;
            checks++;
            if ({at, ac, ah} !== {e.t, e.c, e.h}) begin
                failures++;
                $display("FAIL %s dut%0d: got t=%h con=%h halted=%b, want t=%h con=%h halted=%b",
                         e.n, e.d, at, ac, ah, e.t, e.c, e.h);
            end
        end
        checks++;
        if (!$onehot(ifa.t_state) || !$onehot(ifb.t_state)) begin
            failures++;
            $display("FAIL onehot: got a=%b b=%b, want one-hot", ifa.t_state, ifb.t_state);
        end
    end

    task automatic cyc(input int d, input logic [5:0] t, input logic [11:0] c,
                       input logic h, input string n);
        exp_t e;
        e.d = d; e.t = t; e.c = c; e.h = h; e.n = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.run = 1'b0; ifa.step = 1'b0; ifa.opcode = 4'h0;
        ifb.run = 1'b0; ifb.step = 1'b0; ifb.opcode = 4'h0;
        @(posedge clk); #1;
        cyc(0, 6'h01, 12'h3E3, 1'b0, "reset");

        // LDA full ring
        rst_a = 1'b0; ifa.run = 1'b1; ifa.opcode = 4'h0;
        cyc(0, 6'h01, 12'h5E3, 0, "lda_t1");
        cyc(0, 6'h02, 12'hBE3, 0, "lda_t2");
        cyc(0, 6'h04, 12'h263, 0, "lda_t3");
        cyc(0, 6'h08, 12'h1A3, 0, "lda_t4");
        cyc(0, 6'h10, 12'h2C3, 0, "lda_t5");
        cyc(0, 6'h20, 12'h3E3, 0, "lda_t6");
        cyc(0, 6'h01, 12'h5E3, 0, "lda_wrap");

        ifa.opcode = 4'h1;
        cyc(0, 6'h02, 12'hBE3, 0, "add_t2");
        cyc(0, 6'h04, 12'h263, 0, "add_t3");
        cyc(0, 6'h08, 12'h1A3, 0, "add_t4");
        cyc(0, 6'h10, 12'h2E1, 0, "add_t5");
        cyc(0, 6'h20, 12'h3C7, 0, "add_t6");
        cyc(0, 6'h01, 12'h5E3, 0, "add_wrap");

        ifa.opcode = 4'h2;
        cyc(0, 6'h02, 12'hBE3, 0, "sub_t2");
        cyc(0, 6'h04, 12'h263, 0, "sub_t3");
        cyc(0, 6'h08, 12'h1A3, 0, "sub_t4");
        cyc(0, 6'h10, 12'h2E1, 0, "sub_t5");
        cyc(0, 6'h20, 12'h3CF, 0, "sub_t6");
        cyc(0, 6'h01, 12'h5E3, 0, "sub_wrap");

        // single step: held level gives one advance
        ifa.run = 1'b0; ifa.step = 1'b1;
        cyc(0, 6'h02, 12'hBE3, 0, "step_edge");
        for (int i = 0; i < 4; i++) cyc(0, 6'h04, 12'h263, 0, "step_hold");
        ifa.step = 1'b0;
        cyc(0, 6'h04, 12'h263, 0, "step_low");
        ifa.step = 1'b1;
        cyc(0, 6'h04, 12'h263, 0, "step_edge2");
        ifa.step = 1'b0;
        cyc(0, 6'h08, 12'h1A3, 0, "step_adv2");

        // step edge during run is absorbed
        ifa.run = 1'b1;
        cyc(0, 6'h08, 12'h1A3, 0, "run_resume");
        ifa.step = 1'b1;
        cyc(0, 6'h10, 12'h2E1, 0, "run_step_abs");
        cyc(0, 6'h20, 12'h3CF, 0, "run_step_abs2");
        ifa.run = 1'b0;
        cyc(0, 6'h01, 12'h5E3, 0, "stepq_run");
        cyc(0, 6'h01, 12'h5E3, 0, "stepq_hold");
        ifa.step = 1'b0;

        // HLT
        ifa.run = 1'b1; ifa.opcode = 4'hF;
        cyc(0, 6'h01, 12'h5E3, 0, "hlt_t1");
        cyc(0, 6'h02, 12'hBE3, 0, "hlt_t2");
        cyc(0, 6'h04, 12'h263, 0, "hlt_t3");
        cyc(0, 6'h08, 12'h3E3, 0, "hlt_t4");
        for (int i = 0; i < 20; i++) cyc(0, 6'h08, 12'h3E3, 1, "halted_hold");
        ifa.run = 1'b0; ifa.step = 1'b1;
        cyc(0, 6'h08, 12'h3E3, 1, "halted_step");
        ifa.step = 1'b0; ifa.opcode = 4'h1; ifa.run = 1'b1;
        cyc(0, 6'h08, 12'h3E3, 1, "halted_op_add");
        cyc(0, 6'h08, 12'h3E3, 1, "halted_op_add2");
        rst_a = 1'b1;
        cyc(0, 6'h08, 12'h3E3, 1, "hlt_rst_in");
        cyc(0, 6'h01, 12'h3E3, 0, "hlt_rst_out");

        // reset mid-ADD at T5
        rst_a = 1'b0;
        cyc(0, 6'h01, 12'h5E3, 0, "radd_t1");
        cyc(0, 6'h02, 12'hBE3, 0, "radd_t2");
        cyc(0, 6'h04, 12'h263, 0, "radd_t3");
        cyc(0, 6'h08, 12'h1A3, 0, "radd_t4");
        rst_a = 1'b1;
        cyc(0, 6'h10, 12'h3E3, 0, "radd_t5_rst");
        cyc(0, 6'h01, 12'h3E3, 0, "radd_rst_t1");
        rst_a = 1'b0; ifa.opcode = 4'h5;
        cyc(0, 6'h01, 12'h5E3, 0, "nop_t1");
        cyc(0, 6'h02, 12'hBE3, 0, "nop_t2");
        cyc(0, 6'h04, 12'h263, 0, "nop_t3");
        cyc(0, 6'h08, 12'h3E3, 0, "nop_t4");
        cyc(0, 6'h10, 12'h3E3, 0, "nop_t5");
        cyc(0, 6'h20, 12'h3E3, 0, "nop_t6");
        cyc(0, 6'h01, 12'h5E3, 0, "nop_wrap");
        ifa.opcode = 4'hE;
        cyc(0, 6'h02, 12'hBE3, 0, "out_t2");
        cyc(0, 6'h04, 12'h263, 0, "out_t3");
        cyc(0, 6'h08, 12'h3F2, 0, "out_t4");
        cyc(0, 6'h10, 12'h3E3, 0, "out_t5_full");
        cyc(0, 6'h20, 12'h3E3, 0, "out_t6_full");
        cyc(0, 6'h01, 12'h5E3, 0, "out_wrap_full");
        rst_a = 1'b1;

        // SKIP_IDLE instance
        rst_b = 1'b0; ifb.run = 1'b1; ifb.opcode = 4'hE;
        cyc(1, 6'h01, 12'h5E3, 0, "sk_out_t1");
        cyc(1, 6'h02, 12'hBE3, 0, "sk_out_t2");
        cyc(1, 6'h04, 12'h263, 0, "sk_out_t3");
        cyc(1, 6'h08, 12'h3F2, 0, "sk_out_t4");
        cyc(1, 6'h01, 12'h5E3, 0, "sk_out_wrap");
        cyc(1, 6'h02, 12'hBE3, 0, "sk_out_t2b");
        ifb.opcode = 4'h0;
        cyc(1, 6'h04, 12'h263, 0, "sk_lda_t3");
        cyc(1, 6'h08, 12'h1A3, 0, "sk_lda_t4");
        cyc(1, 6'h10, 12'h2C3, 0, "sk_lda_t5");
        cyc(1, 6'h01, 12'h5E3, 0, "sk_lda_wrap");
        ifb.opcode = 4'h5;
        cyc(1, 6'h02, 12'hBE3, 0, "sk_nop_t2");
        cyc(1, 6'h04, 12'h263, 0, "sk_nop_t3");
        cyc(1, 6'h01, 12'h5E3, 0, "sk_nop_wrap");
        ifb.opcode = 4'h2;
        cyc(1, 6'h02, 12'hBE3, 0, "sk_sub_t2");
        cyc(1, 6'h04, 12'h263, 0, "sk_sub_t3");
        cyc(1, 6'h08, 12'h1A3, 0, "sk_sub_t4");
        cyc(1, 6'h10, 12'h2E1, 0, "sk_sub_t5");
        cyc(1, 6'h20, 12'h3CF, 0, "sk_sub_t6");
        cyc(1, 6'h01, 12'h5E3, 0, "sk_sub_wrap");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
